// File: rtl/regfile_scoreboard_if.sv
// Register file / scoreboard port bundle. The master side belongs to the
// pipeline (decode reads, issue, writeback); the slave side is the register file.
interface regfile_scoreboard_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NRD   = 2
);
    localparam int unsigned AW = $clog2(NREGS);

    // Decode read ports
    logic [NRD*AW-1:0]   A;
    logic [NRD*XLEN-1:0] RD;
    logic [NRD-1:0]      busy;

    // Writeback port
    logic [AW-1:0]       A3;
    logic [XLEN-1:0]     WD3;
    logic                WE3;

    // Issue port and scoreboard occupancy
    logic                iss_valid;
    logic [AW-1:0]       iss_rd;
    logic [AW:0]         pend_cnt;

    modport master (
        output A, A3, WD3, WE3, iss_valid, iss_rd,
        input  RD, busy, pend_cnt
    );

    modport slave (
        input  A, A3, WD3, WE3, iss_valid, iss_rd,
        output RD, busy, pend_cnt
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Integer register file with NRD combinational read ports, one writeback port,
// optional hardwired-zero x0, optional write-to-read bypass and a per-register
// pending-write scoreboard with a registered occupancy count.
module regfile_scoreboard #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned NRD      = 2,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_REG = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    regfile_scoreboard_if.slave bus
);
    localparam int unsigned AW = $clog2(NREGS);

    // True for addresses that hold real, writable state: in range and not a
    // hardwired x0. Reads of any other address return 0 and never look busy.
    function automatic logic addressable(input logic [AW-1:0] a);
        return (32'(a) < NREGS) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    logic [XLEN-1:0] regs_q [NREGS];
    logic [NREGS-1:0] pending_q, pending_d;
    logic [AW:0]      pend_cnt_q, pend_cnt_d;

    logic we_ok;      // writeback targets a real register
    logic iss_ok;     // issue targets a real register
    logic bypass_en;  // writeback is visible to same-cycle reads
    logic cnt_inc;
    logic cnt_dec;

    assign we_ok  = bus.WE3 && addressable(bus.A3);
    assign iss_ok = bus.iss_valid && addressable(bus.iss_rd);

    // Gated by rst_n so that reads stay at 0 while reset is held.
    assign bypass_en = (BYPASS != 0) && rst_n && we_ok;

    // Register array: reset clears every entry, writeback updates one entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < int'(NREGS); r++) begin
                regs_q[r] <= '0;
            end
        end else if (we_ok) begin
            regs_q[bus.A3] <= bus.WD3;
        end
    end

    // Scoreboard next state: clear on writeback first so a same-register issue
    // overrides it (the newly issued producer is still in flight).
    always_comb begin
        pending_d = pending_q;
        cnt_inc   = 1'b0;
        cnt_dec   = 1'b0;

        if (we_ok) begin
            pending_d[bus.A3] = 1'b0;
        end
        if (iss_ok) begin
            pending_d[bus.iss_rd] = 1'b1;
        end

        // Count only real transitions so pend_cnt tracks popcount(pending).
        if (iss_ok && !pending_q[bus.iss_rd]) begin
            cnt_inc = 1'b1;
        end
        if (we_ok && pending_q[bus.A3] && !(iss_ok && (bus.iss_rd == bus.A3))) begin
            cnt_dec = 1'b1;
        end

        pend_cnt_d = pend_cnt_q + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};
    end

    // Scoreboard state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= '0;
            pend_cnt_q <= '0;
        end else begin
            pending_q  <= pending_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    assign bus.pend_cnt = pend_cnt_q;

    // Per-port combinational read data and busy flag.
    for (genvar i = 0; i < int'(NRD); i++) begin : g_port
        logic [AW-1:0]   a;
        logic            live;
        logic            hit;
        logic [XLEN-1:0] rd_val;
        logic            busy_val;

        assign a    = bus.A[i*AW +: AW];
        assign live = addressable(a);
        assign hit  = bypass_en && (bus.A3 == a);

        // Read mux: invalid/x0 -> 0, bypass hit -> WD3, otherwise the array.
        always_comb begin
            rd_val   = '0;
            busy_val = 1'b0;
            if (live) begin
                if (hit) begin
                    rd_val = bus.WD3;
                end else begin
                    rd_val = regs_q[a];
                end
                busy_val = pending_q[a] && !hit;
            end
        end

        assign bus.RD[i*XLEN +: XLEN] = rd_val;
        assign bus.busy[i]            = busy_val;
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: one bypassing and one non-bypassing instance
// share the same stimulus. Stimulus queues expectations; a monitor on the
// falling edge pops and compares them against the live outputs.
module tb_regfile_scoreboard;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned NRD   = 2;
    localparam int unsigned AW    = 5;

    localparam int KRD   = 0;
    localparam int KBUSY = 1;
    localparam int KCNT  = 2;

    localparam int IB = 0;  // BYPASS = 1 instance
    localparam int IN = 1;  // BYPASS = 0 instance

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_scoreboard_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus_b ();
    regfile_scoreboard_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus_n ();

    assign bus_n.A         = bus_b.A;
    assign bus_n.A3        = bus_b.A3;
    assign bus_n.WD3       = bus_b.WD3;
    assign bus_n.WE3       = bus_b.WE3;
    assign bus_n.iss_valid = bus_b.iss_valid;
    assign bus_n.iss_rd    = bus_b.iss_rd;

    regfile_scoreboard #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1), .ZERO_REG(1)
    ) dut_b (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_b.slave)
    );

    regfile_scoreboard #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(0), .ZERO_REG(1)
    ) dut_n (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_n.slave)
    );

    typedef struct {
        string       name;
        int          inst;
        int          kind;
        int          port;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    logic chk_valid = 1'b0;

    function automatic logic [31:0] actual(input int inst, input int kind, input int port);
        logic [NRD*XLEN-1:0] rd;
        logic [NRD-1:0]      bz;
        logic [AW:0]         cnt;
        rd  = (inst == IB) ? bus_b.RD : bus_n.RD;
        bz  = (inst == IB) ? bus_b.busy : bus_n.busy;
        cnt = (inst == IB) ? bus_b.pend_cnt : bus_n.pend_cnt;
        case (kind)
            KRD:     return rd[port*XLEN +: XLEN];
            KBUSY:   return {31'b0, bz[port]};
            default: return 32'(cnt);
        endcase
    endfunction

    // Monitor: compare every queued expectation when a check is presented.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] got;
        if (chk_valid) begin
            while (q.size() > 0) begin
                e   = q.pop_front();
                got = actual(e.inst, e.kind, e.port);
                total++;
                if (got !== e.val) begin
                    bad++;
                    $display("FAIL %s inst=%0d port=%0d: got %0h want %0h",
                             e.name, e.inst, e.port, got, e.val);
                end
            end
        end
    end

    task automatic expect1(input int inst, input int kind, input int port,
                           input logic [31:0] v, input string nm);
        exp_t e;
        e.name = nm;
        e.inst = inst;
        e.kind = kind;
        e.port = port;
        e.val  = v;
        q.push_back(e);
    endtask

    task automatic expect2(input int kind, input int port, input logic [31:0] v,
                           input string nm);
        expect1(IB, kind, port, v, nm);
        expect1(IN, kind, port, v, nm);
    endtask

    task automatic set_a(input int a0, input int a1);
        bus_b.A = {5'(a1), 5'(a0)};
    endtask

    task automatic idle();
        bus_b.WE3       = 1'b0;
        bus_b.iss_valid = 1'b0;
    endtask

    task automatic wb(input int r, input logic [31:0] d);
        bus_b.WE3 = 1'b1;
        bus_b.A3  = 5'(r);
        bus_b.WD3 = d;
    endtask

    task automatic iss(input int r);
        bus_b.iss_valid = 1'b1;
        bus_b.iss_rd    = 5'(r);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_check();
        chk_valid = 1'b1;
        @(posedge clk);
        #1;
        chk_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_b.A = '0;
        bus_b.A3 = '0;
        bus_b.WD3 = '0;
        idle();
        bus_b.iss_rd = '0;
        tick();

        // Reset held: writes ignored, bypass masked, everything reads 0.
        wb(5, 32'hAAAA_AAAA);
        iss(6);
        set_a(5, 6);
        expect2(KRD, 0, 32'h0, "rst_rd_bypass");
        expect2(KBUSY, 1, 32'h0, "rst_busy");
        expect2(KCNT, 0, 32'h0, "rst_cnt");
        tick_check();
        idle();
        tick();
        rst_n = 1'b1;
        expect2(KRD, 0, 32'h0, "rst_no_write");
        expect2(KCNT, 0, 32'h0, "rst_no_issue");
        tick_check();

        // x0: writes and issues are dropped.
        wb(0, 32'hDEAD_BEEF);
        iss(0);
        set_a(0, 0);
        expect2(KRD, 0, 32'h0, "x0_rd_same");
        expect2(KBUSY, 0, 32'h0, "x0_busy_same");
        tick_check();
        idle();
        expect2(KRD, 0, 32'h0, "x0_rd_next");
        expect2(KBUSY, 1, 32'h0, "x0_busy_next");
        expect2(KCNT, 0, 32'h0, "x0_cnt");
        tick_check();

        // Bypass vs no bypass on reg 7.
        wb(7, 32'h1111_1111);
        tick();
        wb(7, 32'hCAFE_F00D);
        set_a(7, 7);
        expect1(IB, KRD, 0, 32'hCAFE_F00D, "byp_rd0");
        expect1(IB, KRD, 1, 32'hCAFE_F00D, "byp_rd1");
        expect1(IN, KRD, 0, 32'h1111_1111, "nobyp_rd0_old");
        expect1(IN, KRD, 1, 32'h1111_1111, "nobyp_rd1_old");
        tick_check();
        idle();
        expect2(KRD, 0, 32'hCAFE_F00D, "rd7_next");
        expect2(KRD, 1, 32'hCAFE_F00D, "rd7_next_p1");
        tick_check();

        // Scoreboard: issue 3 then 9.
        iss(3);
        set_a(3, 9);
        expect2(KCNT, 0, 32'd0, "iss3_cnt_before");
        expect2(KBUSY, 0, 32'h0, "iss3_no_same_cycle");
        tick_check();
        iss(9);
        expect2(KCNT, 0, 32'd1, "iss9_cnt1");
        expect2(KBUSY, 0, 32'h1, "busy3");
        expect2(KBUSY, 1, 32'h0, "busy9_not_yet");
        tick_check();
        idle();
        expect2(KCNT, 0, 32'd2, "cnt2");
        expect2(KBUSY, 1, 32'h1, "busy9");
        tick_check();

        // Writeback 3.
        wb(3, 32'h33);
        expect1(IB, KBUSY, 0, 32'h0, "wb3_busy_byp");
        expect1(IN, KBUSY, 0, 32'h1, "wb3_busy_nobyp");
        expect1(IB, KRD, 0, 32'h33, "wb3_rd_byp");
        expect1(IN, KRD, 0, 32'h0, "wb3_rd_nobyp");
        tick_check();
        idle();
        expect2(KCNT, 0, 32'd1, "wb3_cnt1");
        expect2(KBUSY, 0, 32'h0, "wb3_busy_next");
        expect2(KRD, 0, 32'h33, "wb3_rd_next");
        tick_check();

        // Collision on reg 4: issue wins, data still written.
        iss(4);
        set_a(4, 9);
        tick();
        iss(4);
        wb(4, 32'h55);
        expect2(KCNT, 0, 32'd2, "coll_cnt_before");
        expect1(IB, KBUSY, 0, 32'h0, "coll_busy_byp");
        expect1(IN, KBUSY, 0, 32'h1, "coll_busy_nobyp");
        expect1(IB, KRD, 0, 32'h55, "coll_rd_byp");
        tick_check();
        idle();
        expect2(KBUSY, 0, 32'h1, "coll_busy_next");
        expect2(KRD, 0, 32'h55, "coll_rd_next");
        expect2(KCNT, 0, 32'd2, "coll_cnt_next");
        tick_check();

        // WAW issue, writeback to non-pending, and net-zero issue+retire.
        iss(9);
        tick();
        idle();
        wb(20, 32'h2020);
        tick();
        idle();
        iss(10);
        wb(9, 32'h99);
        tick();
        idle();
        set_a(9, 10);
        expect2(KCNT, 0, 32'd2, "net0_cnt");
        expect2(KBUSY, 0, 32'h0, "busy9_cleared");
        expect2(KBUSY, 1, 32'h1, "busy10_set");
        expect2(KRD, 0, 32'h99, "rd9");
        tick_check();
        set_a(20, 20);
        expect2(KRD, 0, 32'h2020, "rd20_nonpending");
        tick_check();

        // Mid-operation reset discards data and pending state.
        wb(5, 32'h1234);
        tick();
        idle();
        set_a(5, 4);
        expect2(KRD, 0, 32'h1234, "rd5_loaded");
        expect2(KBUSY, 1, 32'h1, "busy4_pre_rst");
        tick_check();
        #2;
        rst_n = 1'b0;
        wb(5, 32'hFFFF_FFFF);
        expect2(KRD, 0, 32'h0, "midrst_rd5");
        expect2(KBUSY, 1, 32'h0, "midrst_busy4");
        expect2(KCNT, 0, 32'h0, "midrst_cnt");
        tick_check();
        idle();
        tick();
        rst_n = 1'b1;
        wb(4, 32'h44);
        set_a(4, 4);
        expect2(KBUSY, 0, 32'h0, "post_rst_busy4");
        tick_check();
        idle();
        expect2(KCNT, 0, 32'd0, "post_rst_wb_cnt");
        expect2(KRD, 0, 32'h44, "post_rst_rd4");
        tick_check();

        // Fill 1..31 back-to-back.
        for (int r = 1; r < 32; r++) begin
            iss(r);
            set_a(r, r);
            expect2(KCNT, 0, 32'(r - 1), "fill_cnt");
            expect2(KBUSY, 0, 32'h0, "fill_busy_same");
            tick_check();
        end
        idle();
        set_a(1, 31);
        expect2(KCNT, 0, 32'd31, "full_cnt");
        expect2(KBUSY, 0, 32'h1, "full_busy1");
        expect2(KBUSY, 1, 32'h1, "full_busy31");
        tick_check();
        iss(5);
        tick();
        iss(0);
        tick();
        idle();
        expect2(KCNT, 0, 32'd31, "full_repeat_cnt");
        tick_check();

        // Drain 1..31.
        for (int r = 1; r < 32; r++) begin
            wb(r, 32'h100 + 32'(r));
            set_a(r, r);
            expect2(KCNT, 0, 32'(32 - r), "drain_cnt");
            expect1(IB, KBUSY, 0, 32'h0, "drain_busy_byp");
            expect1(IN, KBUSY, 0, 32'h1, "drain_busy_nobyp");
            expect1(IB, KRD, 0, 32'h100 + 32'(r), "drain_rd_byp");
            tick_check();
        end
        idle();
        set_a(1, 31);
        expect2(KCNT, 0, 32'd0, "empty_cnt");
        expect2(KRD, 0, 32'h101, "drain_rd1");
        expect2(KRD, 1, 32'h11F, "drain_rd31");
        expect2(KBUSY, 1, 32'h0, "empty_busy31");
        tick_check();

        tick();
        if (q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain: got %0d left want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised integer register file with configurable read-port count, hardwired-zero register, same-cycle write-to-read bypass, and a per-register pending-write scoreboard. It sits in the decode/writeback stages of the pipelined RISC-V core and replaces the fixed 2-read/1-write register file. Decode reads operands and busy flags from it. Issue marks destinations pending, and writeback retires them.

## Interface
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers; AW = $clog2(NREGS).
- NRD, 2, number of read ports (1..4).
- BYPASS, 1, 1 = a same-cycle write is forwarded to reads and clears busy; 0 = no forwarding.
- ZERO_REG, 1, 1 = register 0 reads 0, and writes and issues to it are ignored.

Ports (clock and reset first):
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- A  in  NRD*AW  packed read addresses; port i is A[i*AW +: AW].
- RD  out  NRD*XLEN  packed read data; port i is RD[i*XLEN +: XLEN].
- busy  out  NRD  busy[i] = 1 when the register at port i has an outstanding write.
- A3  in  AW  writeback register address.
- WD3  in  XLEN  writeback data.
- WE3  in  1  writeback enable.
- iss_valid  in  1  issue strobe; marks iss_rd pending.
- iss_rd  in  AW  issued destination register.
- pend_cnt  out  AW+1  number of registers currently pending.

## Operation
- Storage: NREGS x XLEN array plus an NREGS-bit pending vector.
- Write: when WE3 = 1 on a rising clk, reg[A3] <= WD3. Ignored when A3 = 0 and ZERO_REG = 1, or when A3 >= NREGS.
- Read (combinational, per port i):
  - If ZERO_REG = 1 and A[i] = 0, or A[i] >= NREGS: RD = 0.
  - Else if BYPASS = 1, WE3 = 1 and A3 = A[i] with A3 a writable register: RD = WD3.
  - Else: RD = reg[A[i]].
- Busy (combinational, per port i):
  - busy[i] = pending[A[i]], forced to 0 for register 0 (when ZERO_REG = 1) and for out-of-range addresses.
  - With BYPASS = 1, busy[i] is also cleared when WE3 = 1 and A3 = A[i].
  - Issue has no same-cycle effect on busy.
- Scoreboard update on each rising clk:
  - iss_valid with a writable iss_rd sets pending[iss_rd].
  - WE3 with a writable A3 clears pending[A3].
  - Issue and writeback to the same register in the same cycle: issue wins and pending stays 1 (a new producer is in flight). WD3 is still written.
  - Issue to an already-pending register (WAW) keeps it pending; count unchanged.
  - Writeback to a non-pending register writes data; scoreboard and count unchanged.
- pend_cnt: registered.
  - +1 when a clear bit is set.
  - -1 when a set bit is cleared.
  - Net 0 when both happen on different registers.
  - Always equals the popcount of the pending vector; never exceeds NREGS - ZERO_REG.

## Timing
- Reset (rst_n = 0, asynchronous, immediate):
  - All registers = 0, pending = 0, pend_cnt = 0.
  - RD and busy therefore read 0 for every address while reset is held.
  - Writes and issues are ignored while reset is held.
- Reset removal is synchronous to clk; the first update occurs on the first rising edge with rst_n = 1.
- Reset asserted mid-operation discards all pending state; later writebacks to formerly pending registers behave as writes to non-pending registers.
- Read latency:
  - 0 cycles (combinational from A).
  - A written value appears via the array one cycle after the write edge, and in the same cycle via the bypass when BYPASS = 1.
- Scoreboard latency: pending set or clear and pend_cnt are visible 1 cycle after the strobe edge.
- Multiple read ports may address the same register; all return identical data and busy.

## Test plan
- Reset/zero: load reg5 = 0x1234, assert rst_n = 0 mid-cycle → RD for A = 5 is 0 immediately; pend_cnt = 0.
- x0 rule: WE3 = 1, A3 = 0, WD3 = 0xDEADBEEF, plus iss_valid with iss_rd = 0 → RD(A = 0) = 0, busy = 0, pend_cnt = 0.
- Bypass: BYPASS = 1, WE3 = 1, A3 = 7, WD3 = 0xCAFEF00D with both ports at A = 7 → both RD = 0xCAFEF00D in the same cycle; BYPASS = 0 gives the old value until the next cycle.
- Scoreboard:
  - Issue rd = 3, then rd = 9 → pend_cnt goes 1, then 2; busy(A = 3) = 1.
  - Writeback 3 → busy(3) clears (same cycle with BYPASS = 1), and pend_cnt = 1 on the next cycle.
- Collision: reg 4 pending; in one cycle issue rd = 4 and WE3 A3 = 4, WD3 = 0x55 → reg4 = 0x55, busy(4) still 1 next cycle, pend_cnt unchanged.
- Fill/drain: issue all registers 1..31 back-to-back → pend_cnt = 31; retire all → pend_cnt = 0. Repeated issue to a pending register does not change the count.
